// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer. Owns the machine timer, latches
// external/timer interrupt requests, flags illegal-instruction exceptions,
// arbitrates among them and tracks the handler until mret so traps never nest.
module trap_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            irq_ext,
   input  logic            illegal_inst,
   input  logic            stall,
   input  logic            mie,
   input  logic            is_mret,
   input  logic            cmp_wr,
   input  logic [XLEN-1:0] cmp_wdata,
   output logic            interrupt,
   output logic            exception,
   output logic [XLEN-1:0] mcause,
   output logic            in_trap,
   output logic [XLEN-1:0] mtime
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] TRAP    = 2'd1;
   localparam logic [1:0] HANDLER = 2'd2;

   localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
   localparam logic [XLEN-1:0] CAUSE_EXT     = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
   localparam logic [XLEN-1:0] CAUSE_TMR     = {1'b1, {(XLEN-4){1'b0}}, 3'h7};

   logic [1:0]      state_reg, state_next;
   logic [XLEN-1:0] mtime_reg;
   logic [XLEN-1:0] mtimecmp_reg;
   logic [XLEN-1:0] mcause_reg, mcause_next;
   logic            interrupt_reg, interrupt_next;
   logic            tmr_pend_reg;
   logic            ext_pend_reg;
   logic            irq_prev_reg;

   logic            idle;
   logic            exc_now;
   logic            irq_ok;
   logic            take_ext;
   logic            take_tmr;
   logic            ext_rise;
   logic            tmr_match;

   assign idle      = (state_reg == IDLE);
   assign exc_now   = illegal_inst & ~stall;
   assign irq_ok    = ~stall & mie & (ext_pend_reg | tmr_pend_reg) & ~exc_now;
   // External outranks timer; the losing pending bit is left untouched.
   assign take_ext  = idle & irq_ok & ext_pend_reg;
   assign take_tmr  = idle & irq_ok & ~ext_pend_reg & tmr_pend_reg;
   assign ext_rise  = irq_ext & ~irq_prev_reg;
   assign tmr_match = (mtime_reg == mtimecmp_reg);

   // Exception is combinational so the datapath can squash writes this cycle.
   assign exception = exc_now & idle;
   assign interrupt = interrupt_reg;
   assign mcause    = mcause_reg;
   assign in_trap   = (state_reg == TRAP) | (state_reg == HANDLER);
   assign mtime     = mtime_reg;

   // Free-running timer and compare register; a compare write lands next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_reg    <= '0;
         mtimecmp_reg <= '1;
      end else begin
         mtime_reg <= mtime_reg + XLEN'(1);
         if (cmp_wr)
            mtimecmp_reg <= cmp_wdata;
      end
   end

   // Pending-request latches; a compare write beats a same-cycle match.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_pend_reg <= 1'b0;
         ext_pend_reg <= 1'b0;
         irq_prev_reg <= 1'b0;
      end else begin
         irq_prev_reg <= irq_ext;
         if (cmp_wr)
            tmr_pend_reg <= 1'b0;
         else if (tmr_match)
            tmr_pend_reg <= 1'b1;
         else if (take_tmr)
            tmr_pend_reg <= 1'b0;
         if (ext_rise)
            ext_pend_reg <= 1'b1;
         else if (take_ext)
            ext_pend_reg <= 1'b0;
      end
   end

   // Trap FSM next-state and cause selection.
   always_comb begin
      state_next     = state_reg;
      mcause_next    = mcause_reg;
      interrupt_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (exc_now) begin
               state_next  = HANDLER;
               mcause_next = CAUSE_ILLEGAL;
            end else if (irq_ok) begin
               state_next     = TRAP;
               interrupt_next = 1'b1;
               mcause_next    = ext_pend_reg ? CAUSE_EXT : CAUSE_TMR;
            end
         end
         TRAP: begin
            state_next = HANDLER;
         end
         HANDLER: begin
            if (is_mret)
               state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Trap FSM state, interrupt pulse and cause register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         mcause_reg    <= '0;
         interrupt_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mcause_reg    <= mcause_next;
         interrupt_reg <= interrupt_next;
      end
   end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer for the two-stage pipeline. It owns the machine timer (mtime/mtimecomp), latches external and timer interrupt requests, and detects illegal-instruction exceptions. It resolves priority among them and drives the datapath's `interrupt` and `exception` inputs. It then tracks the trap handler until `is_mret` retires, so traps never nest.

## Interface
Parameters:
- `XLEN`, 32, width of mtime, mtimecmp and mcause.

Ports:
- `clk` input 1: system clock. All state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `irq_ext` input 1: external interrupt request, level; only its rising edge is latched.
- `illegal_inst` input 1: decode-stage illegal-instruction flag for `inst_de`.
- `stall` input 1: pipeline stall from the hazard unit. No trap is taken while high.
- `mie` input 1: mstatus.MIE from the CSR file. Gates interrupts only, never exceptions.
- `is_mret` input 1: mret retiring in the MW stage.
- `cmp_wr` input 1: write strobe for mtimecmp.
- `cmp_wdata` input XLEN: new mtimecmp value.
- `interrupt` output 1: one-cycle pulse to the datapath, registered.
- `exception` output 1: exception indication to the datapath, combinational.
- `mcause` output XLEN: cause of the most recent trap, registered.
- `in_trap` output 1: high while a trap handler is active.
- `mtime` output XLEN: free-running cycle counter.

## Operation
- Timer:
  - `mtime` increments every cycle and wraps from 0xFFFF_FFFF to 0.
  - `mtimecmp` resets to 0xFFFF_FFFF.
  - `tmr_pend` sets when `mtime == mtimecmp`.
  - `tmr_pend` clears on `cmp_wr`. `cmp_wr` wins over a same-cycle match.
  - The mtimecmp write takes effect on the next cycle.
- External: `ext_pend` sets on a rising edge of `irq_ext`, detected with a registered previous sample. It clears when the external trap is taken.
- Priority, highest first:
  1. exception (mcause 0x0000_0002)
  2. external (mcause 0x8000_000B)
  3. timer (mcause 0x8000_0007)
- FSM states:
  - IDLE, to TRAP: when `irq_ok = ~stall & mie & (ext_pend | tmr_pend) & ~exc_now`. Latch mcause, clear the winning pending bit.
  - IDLE, to HANDLER: when `exc_now = illegal_inst & ~stall`. Latch mcause = 2.
  - IDLE, otherwise: stay. Pending bits persist with no timeout.
  - TRAP: `interrupt = 1` for exactly this cycle; next state is HANDLER.
  - HANDLER: `in_trap = 1`. No interrupt is taken. Pending bits may still set and stay pending. Goes to IDLE when `is_mret`.
- `exception = illegal_inst & ~stall & (state == IDLE)`, combinational, because the datapath gates `reg_wr` and `wr_en` in the same cycle.
- `illegal_inst` is ignored in TRAP and HANDLER.
- `in_trap = (state == TRAP) | (state == HANDLER)`.
- Same-cycle exception and interrupt: the exception is taken and the interrupt stays pending. It is served after mret.
- Same-cycle ext and timer pending: ext is taken; the timer bit is kept.
- `is_mret` outside HANDLER is ignored.

## Timing
- Reset values, all outputs and state, one cycle after `rst` is sampled high:
  - `mtime` = 0, `mtimecmp` = 0xFFFF_FFFF, pend bits = 0, previous `irq_ext` sample = 0.
  - state = IDLE, `interrupt` = 0, `mcause` = 0, `in_trap` = 0.
- `exception` depends only on inputs and state, so it is 0 during reset because state is IDLE and gated.
- Reset mid-trap (TRAP or HANDLER) returns to IDLE and drops all pending requests.
- Interrupt latency:
  - `irq_ext` rises in cycle N, so `ext_pend` is high in N+1.
  - If eligible in N+1, state = TRAP in N+2 and `interrupt` pulses in N+2.
- Timer match at cycle N (`mtime == mtimecmp`): `tmr_pend` is high in N+1, `interrupt` in N+2 at the earliest.
- Exception: `exception` is high in the same cycle as `illegal_inst`; `in_trap` is high from the next cycle.
- mret: `is_mret` in cycle M (HANDLER), so state = IDLE in M+1. A pending interrupt can reach TRAP in M+2 at the earliest.
- `mcause` updates on the same edge as entry into TRAP or HANDLER and is held until the next trap.

## Test plan
- Reset then run 10 cycles with `stall` = 0: `mtime` = 10, `interrupt` = `exception` = `in_trap` = 0, `mcause` = 0.
- `cmp_wr` with `cmp_wdata` = 20, `mie` = 1:
  - `tmr_pend` is high the cycle after `mtime` = 20, and `interrupt` pulses 1 cycle later.
  - `mcause` = 0x8000_0007, `in_trap` holds until `is_mret`.
- `irq_ext` rise and a timer match in the same cycle, with `mie` = 1:
  - ext is served first (mcause 0x8000_000B).
  - After `is_mret`, the timer trap is taken 2 cycles later (mcause 0x8000_0007).
- `illegal_inst` = 1 with `irq_ext` pending and `stall` = 0:
  - `exception` = 1 in the same cycle, `mcause` = 2, no `interrupt` pulse.
  - The ext interrupt is taken after `is_mret`.
- `stall` = 1 for 5 cycles with `ext_pend` set (or `mie` = 0): no trap and the pend bit is held. Dropping `stall` (or raising `mie`) gives `interrupt` 1 cycle later.
- Assert `rst` while in HANDLER with `tmr_pend` set: the next cycle shows state IDLE, `in_trap` = 0, `mtime` = 0, and no later interrupt.
